// File: rtl/lc3_pkg.sv
// Shared encodings for the pipelined LC-3 execute stage: ALU ops, address-adder
// base select, e_control field positions and writeback-select codes.
package lc3_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC1_OFF6  = 2'b00,
        PC1_OFF9  = 2'b01,
        PC1_OFF11 = 2'b10,
        PC1_ZERO  = 2'b11
    } pc_sel1_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_PC   = 2'b01,
        WB_MEM  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    localparam int EC_ALU_OP_HI  = 5;
    localparam int EC_ALU_OP_LO  = 4;
    localparam int EC_PC_SEL1_HI = 3;
    localparam int EC_PC_SEL1_LO = 2;
    localparam int EC_PC_SEL2    = 1;
    localparam int EC_OP2_SEL    = 0;

    // Writeback select forced onto the output when a bubble passes through.
    localparam logic [1:0] W_CTL_BUBBLE = 2'b00;

endpackage

// File: rtl/lc3_execute_pipe_if.sv
// Decode-to-execute-to-memory bundle. master = the side that feeds the stage
// (Decode/forwarding logic), slave = the execute stage itself.
interface lc3_execute_pipe_if #(
    parameter int DW = 16
) ();
    logic          enable_execute;
    logic          in_valid;
    logic [15:0]   ir;
    logic [5:0]    e_control;
    logic [1:0]    w_control_in;
    logic          mem_control_in;
    logic [DW-1:0] vsr1;
    logic [DW-1:0] vsr2;
    logic [DW-1:0] npc;
    logic          bypass_alu_1;
    logic          bypass_alu_2;
    logic          bypass_mem_1;
    logic          bypass_mem_2;
    logic [DW-1:0] mem_bypass_val;

    logic [DW-1:0] aluout;
    logic [DW-1:0] pcout;
    logic [DW-1:0] m_data;
    logic [2:0]    dr;
    logic [1:0]    w_control_out;
    logic          mem_control_out;
    logic [2:0]    nzp;
    logic          out_valid;

    modport master (
        output enable_execute, in_valid, ir, e_control, w_control_in, mem_control_in,
               vsr1, vsr2, npc, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               mem_bypass_val,
        input  aluout, pcout, m_data, dr, w_control_out, mem_control_out, nzp, out_valid
    );

    modport slave (
        input  enable_execute, in_valid, ir, e_control, w_control_in, mem_control_in,
               vsr1, vsr2, npc, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               mem_bypass_val,
        output aluout, pcout, m_data, dr, w_control_out, mem_control_out, nzp, out_valid
    );
endinterface

// File: rtl/lc3_alu.sv
// Combinational LC-3 ALU: ADD / AND / NOT a / PASS a, modulo 2^DW.
module lc3_alu
    import lc3_pkg::*;
#(
    parameter int DW = 16
) (
    input  alu_op_e       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_AND:  y = a & b;
            ALU_NOT:  y = ~a;
            ALU_PASS: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/lc3_execute_pipe.sv
// Registered LC-3 execute stage: operand forwarding, ALU, address adder and a
// single output register with stall, bubble clearing and N/Z/P generation.
module lc3_execute_pipe
    import lc3_pkg::*;
#(
    parameter int DW     = 16,
    parameter int FWD_EN = 1
) (
    input  logic               clock,
    input  logic               reset,
    lc3_execute_pipe_if.slave  bus
);

    localparam bit FWD = (FWD_EN != 0);

    alu_op_e       alu_op;
    pc_sel1_e      pc_sel1;
    logic          pc_sel2;
    logic          op2_sel;

    logic [DW-1:0] fwd1, fwd2, alu_b, alu_y, imm5;
    logic [DW-1:0] addr_opr1, addr_opr2, pc_sum;
    logic [2:0]    nzp_calc;

    logic [DW-1:0] aluout_q, aluout_d;
    logic [DW-1:0] pcout_q, pcout_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [2:0]    dr_q, dr_d;
    logic [1:0]    w_control_q, w_control_d;
    logic          mem_control_q, mem_control_d;
    logic [2:0]    nzp_q, nzp_d;
    logic          out_valid_q, out_valid_d;

    logic          unused_ir;

    assign alu_op  = alu_op_e'(bus.e_control[EC_ALU_OP_HI:EC_ALU_OP_LO]);
    assign pc_sel1 = pc_sel1_e'(bus.e_control[EC_PC_SEL1_HI:EC_PC_SEL1_LO]);
    assign pc_sel2 = bus.e_control[EC_PC_SEL2];
    assign op2_sel = bus.e_control[EC_OP2_SEL];

    // The ALU bypass reads the registered aluout, so a stalled result keeps forwarding.
    always_comb begin
        fwd1 = bus.vsr1;
        fwd2 = bus.vsr2;
        if (FWD && bus.bypass_alu_1)      fwd1 = aluout_q;
        else if (FWD && bus.bypass_mem_1) fwd1 = bus.mem_bypass_val;
        if (FWD && bus.bypass_alu_2)      fwd2 = aluout_q;
        else if (FWD && bus.bypass_mem_2) fwd2 = bus.mem_bypass_val;
    end

    assign imm5  = {{(DW-5){bus.ir[4]}}, bus.ir[4:0]};
    assign alu_b = op2_sel ? imm5 : fwd2;

    lc3_alu #(.DW(DW)) u_alu (
        .op (alu_op),
        .a  (fwd1),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_comb begin
        addr_opr1 = '0;
        case (pc_sel1)
            PC1_OFF6:  addr_opr1 = {{(DW-6){bus.ir[5]}},   bus.ir[5:0]};
            PC1_OFF9:  addr_opr1 = {{(DW-9){bus.ir[8]}},   bus.ir[8:0]};
            PC1_OFF11: addr_opr1 = {{(DW-11){bus.ir[10]}}, bus.ir[10:0]};
            PC1_ZERO:  addr_opr1 = '0;
            default:   addr_opr1 = '0;
        endcase
    end

    assign addr_opr2 = pc_sel2 ? fwd1 : bus.npc;
    assign pc_sum    = addr_opr1 + addr_opr2;

    always_comb begin
        nzp_calc = 3'b001;
        if (alu_y[DW-1])       nzp_calc = 3'b100;
        else if (alu_y == '0)  nzp_calc = 3'b010;
    end

    // A bubble only kills the control outputs; datapath registers keep their last value.
    always_comb begin
        aluout_d      = aluout_q;
        pcout_d       = pcout_q;
        m_data_d      = m_data_q;
        dr_d          = dr_q;
        w_control_d   = w_control_q;
        mem_control_d = mem_control_q;
        nzp_d         = nzp_q;
        out_valid_d   = out_valid_q;
        if (bus.enable_execute) begin
            if (bus.in_valid) begin
                aluout_d      = alu_y;
                pcout_d       = pc_sum;
                m_data_d      = fwd2;
                dr_d          = bus.ir[11:9];
                w_control_d   = bus.w_control_in;
                mem_control_d = bus.mem_control_in;
                nzp_d         = nzp_calc;
                out_valid_d   = 1'b1;
            end else begin
                w_control_d   = W_CTL_BUBBLE;
                mem_control_d = 1'b0;
                out_valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout_q      <= '0;
            pcout_q       <= '0;
            m_data_q      <= '0;
            dr_q          <= '0;
            w_control_q   <= '0;
            mem_control_q <= 1'b0;
            nzp_q         <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            aluout_q      <= aluout_d;
            pcout_q       <= pcout_d;
            m_data_q      <= m_data_d;
            dr_q          <= dr_d;
            w_control_q   <= w_control_d;
            mem_control_q <= mem_control_d;
            nzp_q         <= nzp_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign bus.aluout          = aluout_q;
    assign bus.pcout           = pcout_q;
    assign bus.m_data          = m_data_q;
    assign bus.dr              = dr_q;
    assign bus.w_control_out   = w_control_q;
    assign bus.mem_control_out = mem_control_q;
    assign bus.nzp             = nzp_q;
    assign bus.out_valid       = out_valid_q;

    // Opcode bits are consumed by Decode; execute only sees their effect via e_control.
    assign unused_ir = ^bus.ir[15:12];

endmodule

// File: tb/tb_lc3_execute_pipe.sv
// Directed bench for lc3_execute_pipe: a DW=16 forwarding instance and a DW=32
// instance with forwarding disabled, checked against a queue of expected outputs.
module tb_lc3_execute_pipe;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] mdata;
        logic [2:0]  dr;
        logic [1:0]  w;
        logic        mem;
        logic [2:0]  nzp;
        logic        v;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exp_t exp16_q[$];
    exp_t exp32_q[$];

    logic [15:0] ra, rb, rn, rs;

    lc3_execute_pipe_if #(.DW(16)) bus16 ();
    lc3_execute_pipe_if #(.DW(32)) bus32 ();

    lc3_execute_pipe #(.DW(16), .FWD_EN(1)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
    lc3_execute_pipe #(.DW(32), .FWD_EN(0)) dut32 (.clock(clock), .reset(reset), .bus(bus32));

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(logic [31:0] alu, logic [31:0] pc, logic [31:0] md,
                                logic [2:0] dr, logic [1:0] w, logic mem,
                                logic [2:0] nzp, logic v);
        exp_t e;
        e.alu = alu; e.pc = pc; e.mdata = md; e.dr = dr;
        e.w = w; e.mem = mem; e.nzp = nzp; e.v = v;
        return e;
    endfunction

    function automatic logic [2:0] nzp16(logic [15:0] r);
        if (r[15])       return 3'b100;
        else if (r == 0) return 3'b010;
        else             return 3'b001;
    endfunction

    function automatic exp_t obs(bit wide);
        exp_t o;
        if (wide) begin
            o = mk(bus32.aluout, bus32.pcout, bus32.m_data, bus32.dr, bus32.w_control_out,
                   bus32.mem_control_out, bus32.nzp, bus32.out_valid);
        end else begin
            o = mk({16'h0, bus16.aluout}, {16'h0, bus16.pcout}, {16'h0, bus16.m_data}, bus16.dr,
                   bus16.w_control_out, bus16.mem_control_out, bus16.nzp, bus16.out_valid);
        end
        return o;
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cmp_fields(string tag, exp_t o, exp_t e);
        chk($sformatf("%s.aluout", tag), o.alu, e.alu);
        chk($sformatf("%s.pcout", tag), o.pc, e.pc);
        chk($sformatf("%s.m_data", tag), o.mdata, e.mdata);
        chk($sformatf("%s.dr", tag), {29'h0, o.dr}, {29'h0, e.dr});
        chk($sformatf("%s.w_control_out", tag), {30'h0, o.w}, {30'h0, e.w});
        chk($sformatf("%s.mem_control_out", tag), {31'h0, o.mem}, {31'h0, e.mem});
        chk($sformatf("%s.nzp", tag), {29'h0, o.nzp}, {29'h0, e.nzp});
        chk($sformatf("%s.out_valid", tag), {31'h0, o.v}, {31'h0, e.v});
    endtask

    // Push expectation, let one edge pass, then compare at the following falling edge.
    task automatic tick(bit wide, string tag, exp_t e);
        exp_t p;
        if (wide) exp32_q.push_back(e);
        else      exp16_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        checks++;
        assert ((wide ? exp32_q.size() : exp16_q.size()) != 0) else begin
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end
        if (wide && exp32_q.size() != 0) begin
            p = exp32_q.pop_front();
            cmp_fields(tag, obs(1'b1), p);
        end else if (!wide && exp16_q.size() != 0) begin
            p = exp16_q.pop_front();
            cmp_fields(tag, obs(1'b0), p);
        end
    endtask

    task automatic set16(logic [15:0] ir, logic [5:0] ec, logic [1:0] wc, logic mc,
                         logic [15:0] v1, logic [15:0] v2, logic [15:0] npc);
        bus16.enable_execute = 1'b1; bus16.in_valid = 1'b1;
        bus16.ir = ir; bus16.e_control = ec; bus16.w_control_in = wc; bus16.mem_control_in = mc;
        bus16.vsr1 = v1; bus16.vsr2 = v2; bus16.npc = npc;
        bus16.bypass_alu_1 = 1'b0; bus16.bypass_alu_2 = 1'b0;
        bus16.bypass_mem_1 = 1'b0; bus16.bypass_mem_2 = 1'b0;
        bus16.mem_bypass_val = '0;
    endtask

    task automatic set32(logic [15:0] ir, logic [5:0] ec, logic [1:0] wc, logic mc,
                         logic [31:0] v1, logic [31:0] v2, logic [31:0] npc);
        bus32.enable_execute = 1'b1; bus32.in_valid = 1'b1;
        bus32.ir = ir; bus32.e_control = ec; bus32.w_control_in = wc; bus32.mem_control_in = mc;
        bus32.vsr1 = v1; bus32.vsr2 = v2; bus32.npc = npc;
        bus32.bypass_alu_1 = 1'b0; bus32.bypass_alu_2 = 1'b0;
        bus32.bypass_mem_1 = 1'b0; bus32.bypass_mem_2 = 1'b0;
        bus32.mem_bypass_val = '0;
    endtask

    task automatic scramble16();
        bus16.in_valid = 1'($urandom_range(0, 1));
        bus16.ir = 16'($urandom_range(0, 65535));
        bus16.e_control = 6'($urandom_range(0, 63));
        bus16.w_control_in = 2'($urandom_range(0, 3));
        bus16.mem_control_in = 1'($urandom_range(0, 1));
        bus16.vsr1 = 16'($urandom_range(0, 65535));
        bus16.vsr2 = 16'($urandom_range(0, 65535));
        bus16.npc = 16'($urandom_range(0, 65535));
        bus16.bypass_alu_1 = 1'($urandom_range(0, 1));
        bus16.bypass_alu_2 = 1'($urandom_range(0, 1));
        bus16.bypass_mem_1 = 1'($urandom_range(0, 1));
        bus16.bypass_mem_2 = 1'($urandom_range(0, 1));
        bus16.mem_bypass_val = 16'($urandom_range(0, 65535));
    endtask

    initial begin
        set16(16'h0, 6'h0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
        set32(16'h0, 6'h0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        bus32.enable_execute = 1'b0;

        // Reset held with active, changing inputs: everything must stay zero.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            scramble16();
            bus16.enable_execute = 1'b1;
            bus16.in_valid = 1'b1;
        end
        @(negedge clock);
        cmp_fields("reset16", obs(1'b0), mk(0, 0, 0, 0, 0, 0, 0, 0));
        cmp_fields("reset32", obs(1'b1), mk(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;

        set16(16'h1200, 6'b000000, 2'b01, 1'b0, 16'd5, 16'd3, 16'h3001);
        tick(0, "add_5_3", mk(16'd8, 16'h3001, 16'd3, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        set16(16'h143F, 6'b000001, 2'b01, 1'b0, 16'd1, 16'h0055, 16'h3002);
        tick(0, "add_imm_m1", mk(16'h0000, 16'h3001, 16'h0055, 3'd2, 2'b01, 1'b0, 3'b010, 1'b1));

        set16(16'h963F, 6'b100000, 2'b01, 1'b0, 16'h00FF, 16'h1234, 16'h3003);
        tick(0, "not_00ff", mk(16'hFF00, 16'h3002, 16'h1234, 3'd3, 2'b01, 1'b0, 3'b100, 1'b1));

        set16(16'h29FE, 6'b110100, 2'b10, 1'b1, 16'h8000, 16'h0007, 16'h3000);
        tick(0, "pc_off9", mk(16'h8000, 16'h2FFE, 16'h0007, 3'd4, 2'b10, 1'b1, 3'b100, 1'b1));

        set16(16'hC080, 6'b111110, 2'b00, 1'b0, 16'h4000, 16'h0000, 16'h3005);
        tick(0, "base_reg", mk(16'h4000, 16'h4000, 16'h0000, 3'd0, 2'b00, 1'b0, 3'b001, 1'b1));

        set16(16'h1200, 6'b000000, 2'b01, 1'b0, 16'd3, 16'd4, 16'h3006);
        tick(0, "add_7", mk(16'd7, 16'h3006, 16'd4, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        set16(16'h1200, 6'b000000, 2'b01, 1'b0, 16'd0, 16'd1, 16'h3007);
        bus16.bypass_alu_1 = 1'b1;
        tick(0, "fwd_alu1", mk(16'd8, 16'h3007, 16'd1, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        set16(16'h1200, 6'b000000, 2'b01, 1'b0, 16'd2, 16'h0077, 16'h3008);
        bus16.bypass_alu_2 = 1'b1; bus16.bypass_mem_2 = 1'b1; bus16.mem_bypass_val = 16'd100;
        tick(0, "fwd_alu_prio", mk(16'd10, 16'h3008, 16'd8, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        set16(16'h1200, 6'b001110, 2'b01, 1'b0, 16'd5, 16'd3, 16'h3009);
        bus16.bypass_mem_1 = 1'b1; bus16.mem_bypass_val = 16'hFFF0;
        tick(0, "fwd_mem1", mk(16'hFFF3, 16'hFFF0, 16'd3, 3'd1, 2'b01, 1'b0, 3'b100, 1'b1));

        set16(16'h5200, 6'b010000, 2'b01, 1'b0, 16'h0F0F, 16'h1234, 16'h300A);
        bus16.bypass_mem_2 = 1'b1; bus16.mem_bypass_val = 16'h00FF;
        tick(0, "fwd_mem2_and", mk(16'h000F, 16'h300A, 16'h00FF, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        for (int i = 0; i < 3; i++) begin
            scramble16();
            bus16.enable_execute = 1'b0;
            tick(0, "stall", mk(16'h000F, 16'h300A, 16'h00FF, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));
        end

        set16(16'h1200, 6'b000000, 2'b11, 1'b1, 16'd0, 16'd1, 16'h300E);
        bus16.bypass_alu_1 = 1'b1;
        tick(0, "fwd_after_stall", mk(16'h0010, 16'h300E, 16'd1, 3'd1, 2'b11, 1'b1, 3'b001, 1'b1));

        set16(16'h5E00, 6'b010000, 2'b10, 1'b1, 16'hAAAA, 16'h5555, 16'h1111);
        bus16.in_valid = 1'b0;
        tick(0, "bubble", mk(16'h0010, 16'h300E, 16'd1, 3'd1, 2'b00, 1'b0, 3'b001, 1'b0));

        set16(16'h1200, 6'b000000, 2'b01, 1'b1, 16'd9, 16'd9, 16'h2222);
        bus16.enable_execute = 1'b0;
        tick(0, "stall_bubble", mk(16'h0010, 16'h300E, 16'd1, 3'd1, 2'b00, 1'b0, 3'b001, 1'b0));

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rn = 16'($urandom_range(0, 65535));
            rs = ra + rb;
            set16(16'h1200, 6'b000000, 2'b01, 1'b0, ra, rb, rn);
            tick(0, "rand_add", mk({16'h0, rs}, {16'h0, rn}, {16'h0, rb}, 3'd1, 2'b01, 1'b0, nzp16(rs), 1'b1));
        end

        // Reset arriving while stalled with a live instruction in the register.
        set16(16'h1200, 6'b000000, 2'b01, 1'b0, 16'd1, 16'd1, 16'h3020);
        tick(0, "pre_reset", mk(16'd2, 16'h3020, 16'd1, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));
        bus16.enable_execute = 1'b0;
        reset = 1'b0;
        #1;
        cmp_fields("async_reset", obs(1'b0), mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b1;
        set16(16'h1200, 6'b000000, 2'b01, 1'b0, 16'd2, 16'd3, 16'h3030);
        tick(0, "post_reset", mk(16'd5, 16'h3030, 16'd3, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        bus16.enable_execute = 1'b0;

        set32(16'h5200, 6'b010000, 2'b01, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00010000);
        tick(1, "w32_and", mk(32'h0F0F0000, 32'h00010000, 32'h0F0F0F0F, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        set32(16'h4C00, 6'b111000, 2'b01, 1'b0, 32'h0, 32'h0, 32'h00010000);
        tick(1, "w32_off11", mk(32'h0, 32'h0000FC00, 32'h0, 3'd6, 2'b01, 1'b0, 3'b010, 1'b1));

        set32(16'h1200, 6'b000000, 2'b01, 1'b0, 32'h7, 32'h8, 32'h00020000);
        bus32.bypass_alu_1 = 1'b1; bus32.bypass_mem_2 = 1'b1; bus32.mem_bypass_val = 32'h5;
        tick(1, "w32_nofwd", mk(32'hF, 32'h00020000, 32'h8, 3'd1, 2'b01, 1'b0, 3'b001, 1'b1));

        set32(16'h1230, 6'b000001, 2'b01, 1'b0, 32'h0, 32'h3, 32'h00000100);
        tick(1, "w32_imm_neg", mk(32'hFFFFFFF0, 32'h000000F0, 32'h3, 3'd1, 2'b01, 1'b0, 3'b100, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
